de_stage_fwd_param: RTL and testbench
=====================================

Name: de_stage_fwd_param

Overview:
- Parametrised decode-stage operand unit: register file, N-channel forwarding network, load-use interlock and branch-wait FSM, feeding a registered DE output latch.
- Sits between the FE latch and AGEX.
- Inputs are pre-decoded instruction fields. The ISA decoder stays outside.
- Generalises the single-AGEX/single-MEM bypass to NFWD ordered channels with per-channel ready flags, plus stall performance counters.

Parameters:
- DBITS, 32, data/register width.
- REGS, 16, number of architectural registers (power of 2).
- RBITS, 4, register-number width, log2(REGS).
- NFWD, 2, forwarding channels. Index 0 is youngest (AGEX), higher indices are older (MEM, ...).
- ZERO_HARD, 0, 1 = register 0 reads 0 and ignores writes and forwarding.
- CNTBITS, 16, performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  FE latch holds a real instruction
- in_rs  in  RBITS  source register 1
- in_rt  in  RBITS  source register 2
- in_read_rs  in  1  instruction reads rs
- in_read_rt  in  1  instruction reads rt
- in_wr_reg  in  1  instruction writes a register
- in_wregno  in  RBITS  destination register
- in_is_br  in  1  branch or jump
- fwd_valid  in  NFWD  channel i holds a register-writing instruction
- fwd_ready  in  NFWD  channel i data is available (0 = load not yet returned)
- fwd_regno  in  NFWD*RBITS  channel i destination register, packed with i at LSBs
- fwd_data  in  NFWD*DBITS  channel i value, packed with i at LSBs
- wb_we  in  1  writeback enable
- wb_regno  in  RBITS  writeback register
- wb_data  in  DBITS  writeback value
- br_resolve  in  1  branch outcome known (one-cycle pulse from AGEX)
- flush  in  1  squash DE latch and branch wait
- stall_fe  out  1  combinational: FE must hold its latch
- out_valid  out  1  DE latch valid
- out_rs_val  out  DBITS  latched operand 1
- out_rt_val  out  DBITS  latched operand 2
- out_wr_reg  out  1  latched write enable
- out_wregno  out  RBITS  latched destination register
- out_is_br  out  1  latched branch flag
- cnt_lu_stall  out  CNTBITS  load-use stall cycles
- cnt_br_stall  out  CNTBITS  branch-wait cycles

Behaviour:
- Reset (asynchronous):
  - all out_* = 0, both counters = 0, FSM = RUN, all registers = 0.
- Register file:
  - Written on posedge clk when wb_we=1.
  - A same-cycle read of wb_regno returns wb_data (write-through bypass).
- Operand selection, per source:
  - Channel match: fwd_valid[i] && fwd_regno_i == src.
  - The lowest-index matching channel wins.
  - No channel matches: use the WB bypass if wb_we && wb_regno == src, else the register file.
  - ZERO_HARD=1 and src=0: value is 0, hazards are suppressed.
  - An unread source (read_*=0) never causes a hazard and its latched value is don't-care.
- Load-use condition: in_valid, a read source, and its winning channel has fwd_ready=0. Older channels do not override a not-ready younger match.
- FSM RUN:
  - lu = load-use condition && !flush.
  - lu: stall_fe=1; latch loads a bubble (out_valid=0, other out_* = 0); cnt_lu_stall increments, saturating.
  - Otherwise: latch loads the inputs with out_valid=in_valid.
  - If in_valid && in_is_br && !lu: next state BRWAIT.
- FSM BRWAIT:
  - stall_fe=1; latch loads a bubble each cycle; cnt_br_stall increments, saturating.
  - br_resolve=1: next state RUN. stall_fe stays 1 in that cycle and FE proceeds the next cycle.
- flush (highest priority, either state):
  - Latch loads a bubble and next state is RUN.
  - stall_fe=0 in the flush cycle and counters do not increment.
  - in_valid is ignored that cycle.
- Branch with a load-use hazard: stalls first and enters BRWAIT only when issued.
- br_resolve while in RUN is ignored.
- Counters saturate at all ones and never wrap.

Test Plan:
- Forward priority:
  - Stimulus: NFWD=2, ch0 r3=0x11 ready, ch1 r3=0x22 ready, regfile r3=0x33, in rs=3 read_rs=1.
  - Required: next cycle out_rs_val=0x11, stall_fe=0.
- Load-use:
  - Stimulus: ch0 r5 ready=0, in rt=5 read_rt=1, for 1 cycle; then ch0 invalid, ch1 r5=0x7 ready.
  - Required: cycle 1 stall_fe=1, out_valid=0, cnt_lu_stall=1; cycle 2 out_valid=1, out_rt_val=0x7.
- WB bypass:
  - Stimulus: wb_we=1 r9=0xABCD in the same cycle as in rs=9, no channel match.
  - Required: out_rs_val=0xABCD; a later read of r9 from the regfile also gives 0xABCD.
- Branch wait:
  - Stimulus: issue in_is_br=1, hold 3 cycles, then br_resolve pulse.
  - Required: branch latched with out_valid=1; then 4 bubble cycles with stall_fe=1; cnt_br_stall=4; RUN afterwards.
- Flush and reset:
  - Stimulus: flush during BRWAIT.
  - Required: RUN next cycle, out_valid=0.
  - Stimulus: async reset mid-stall.
  - Required: all outputs and counters 0 immediately; regfile reads 0.
- Unread source and ZERO_HARD:
  - Stimulus: ch0 r0 ready=0 with src=0; ZERO_HARD=1.
  - Required: no stall, operand 0.
  - Stimulus: ZERO_HARD=0 with the same inputs.
  - Required: stall.

Source files
------------

// File: rtl/de_stage_fwd_param.sv
// Decode-stage operand unit: register file, ordered N-channel forwarding network,
// load-use interlock, branch-wait FSM and the registered DE output latch.
module de_stage_fwd_param #(
  parameter int DBITS     = 32,
  parameter int REGS      = 16,
  parameter int RBITS     = 4,
  parameter int NFWD      = 2,
  parameter int ZERO_HARD = 0,
  parameter int CNTBITS   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [RBITS-1:0]        in_rs,
  input  logic [RBITS-1:0]        in_rt,
  input  logic                    in_read_rs,
  input  logic                    in_read_rt,
  input  logic                    in_wr_reg,
  input  logic [RBITS-1:0]        in_wregno,
  input  logic                    in_is_br,
  input  logic [NFWD-1:0]         fwd_valid,
  input  logic [NFWD-1:0]         fwd_ready,
  input  logic [NFWD*RBITS-1:0]   fwd_regno,
  input  logic [NFWD*DBITS-1:0]   fwd_data,
  input  logic                    wb_we,
  input  logic [RBITS-1:0]        wb_regno,
  input  logic [DBITS-1:0]        wb_data,
  input  logic                    br_resolve,
  input  logic                    flush,
  output logic                    stall_fe,
  output logic                    out_valid,
  output logic [DBITS-1:0]        out_rs_val,
  output logic [DBITS-1:0]        out_rt_val,
  output logic                    out_wr_reg,
  output logic [RBITS-1:0]        out_wregno,
  output logic                    out_is_br,
  output logic [CNTBITS-1:0]      cnt_lu_stall,
  output logic [CNTBITS-1:0]      cnt_br_stall
);

  typedef enum logic {RUN, BRWAIT} state_t;

  typedef struct packed {
    logic             hazard;
    logic [DBITS-1:0] value;
  } opnd_t;

  state_t           state, state_nxt;
  logic [DBITS-1:0] regs [REGS];
  opnd_t            rs_op, rt_op;
  logic             lu;
  logic             load_bubble;
  logic             inc_lu;
  logic             inc_br;
  logic             wb_write;

  // Youngest matching channel wins even when it is not ready; an older ready
  // copy of the same register would be stale.
  function automatic opnd_t select_operand(
    input logic [RBITS-1:0]      src,
    input logic                  rd,
    input logic [DBITS-1:0]      rf_val,
    input logic [NFWD-1:0]       fv,
    input logic [NFWD-1:0]       fr,
    input logic [NFWD*RBITS-1:0] fn,
    input logic [NFWD*DBITS-1:0] fd,
    input logic                  we,
    input logic [RBITS-1:0]      wn,
    input logic [DBITS-1:0]      wd
  );
    opnd_t r;
    logic  hit;
    r.hazard = 1'b0;
    r.value  = (we && wn == src) ? wd : rf_val;
    hit      = 1'b0;
    for (int i = 0; i < NFWD; i++) begin
      if (!hit && fv[i] && fn[i*RBITS +: RBITS] == src) begin
        hit      = 1'b1;
        r.value  = fd[i*DBITS +: DBITS];
        r.hazard = rd && !fr[i];
      end
    end
    if (ZERO_HARD != 0 && src == '0) begin
      r.value  = '0;
      r.hazard = 1'b0;
    end
    return r;
  endfunction

  assign rs_op = select_operand(in_rs, in_read_rs, regs[in_rs], fwd_valid, fwd_ready,
                                fwd_regno, fwd_data, wb_we, wb_regno, wb_data);
  assign rt_op = select_operand(in_rt, in_read_rt, regs[in_rt], fwd_valid, fwd_ready,
                                fwd_regno, fwd_data, wb_we, wb_regno, wb_data);

  assign lu       = in_valid && (rs_op.hazard || rt_op.hazard) && !flush;
  assign wb_write = wb_we && !(ZERO_HARD != 0 && wb_regno == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[wb_regno] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Flush overrides everything and releases FE in the same cycle.
  always_comb begin
    state_nxt   = state;
    stall_fe    = 1'b0;
    load_bubble = 1'b1;
    inc_lu      = 1'b0;
    inc_br      = 1'b0;
    if (flush) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (lu) begin
            stall_fe = 1'b1;
            inc_lu   = 1'b1;
          end else begin
            load_bubble = 1'b0;
            if (in_valid && in_is_br) state_nxt = BRWAIT;
          end
        end
        BRWAIT: begin
          stall_fe = 1'b1;
          inc_br   = 1'b1;
          if (br_resolve) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_rs_val <= '0;
      out_rt_val <= '0;
      out_wr_reg <= 1'b0;
      out_wregno <= '0;
      out_is_br  <= 1'b0;
    end else if (load_bubble) begin
      out_valid  <= 1'b0;
      out_rs_val <= '0;
      out_rt_val <= '0;
      out_wr_reg <= 1'b0;
      out_wregno <= '0;
      out_is_br  <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      out_rs_val <= rs_op.value;
      out_rt_val <= rt_op.value;
      out_wr_reg <= in_wr_reg;
      out_wregno <= in_wregno;
      out_is_br  <= in_is_br;
    end
  end

  // Performance counters stick at all ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_lu_stall <= '0;
      cnt_br_stall <= '0;
    end else begin
      if (inc_lu && cnt_lu_stall != '1) cnt_lu_stall <= cnt_lu_stall + CNTBITS'(1);
      if (inc_br && cnt_br_stall != '1) cnt_br_stall <= cnt_br_stall + CNTBITS'(1);
    end
  end

endmodule

// File: tb/tb_de_stage_fwd_param.sv
// Bench for de_stage_fwd_param: two instances (ZERO_HARD=0 with 16-bit counters,
// ZERO_HARD=1 with 4-bit counters) compared against a rule-level model.
module tb_de_stage_fwd_param;

  localparam int DB = 32;
  localparam int RB = 4;
  localparam int NF = 2;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_read_rs, in_read_rt, in_wr_reg, in_is_br;
  logic [RB-1:0] in_rs, in_rt, in_wregno, wb_regno;
  logic [NF-1:0] fwd_valid, fwd_ready;
  logic [NF*RB-1:0] fwd_regno;
  logic [NF*DB-1:0] fwd_data;
  logic wb_we, br_resolve, flush;
  logic [DB-1:0] wb_data;

  logic o_stall [2];
  logic o_valid [2];
  logic [DB-1:0] o_rs [2];
  logic [DB-1:0] o_rt [2];
  logic o_wr [2];
  logic [RB-1:0] o_wregno [2];
  logic o_br [2];
  logic [15:0] c0_lu, c0_br;
  logic [3:0] c1_lu, c1_br;

  int n_pass = 0;
  int n_checks = 0;

  // reference model state, index 0/1 = ZERO_HARD 0/1
  logic [DB-1:0] m_regs [2][16];
  bit m_brwait [2];
  int m_lu [2];
  int m_brc [2];
  int cmax [2] = '{65535, 15};
  bit e_valid [2];
  logic [DB-1:0] e_rs [2];
  logic [DB-1:0] e_rt [2];
  bit e_rdrs [2];
  bit e_rdrt [2];
  bit e_wr [2];
  logic [RB-1:0] e_wregno [2];
  bit e_br [2];
  bit e_stall [2];
  bit n_valid [2];
  logic [DB-1:0] n_rs [2];
  logic [DB-1:0] n_rt [2];
  bit n_rdrs [2];
  bit n_rdrt [2];
  bit n_wr [2];
  logic [RB-1:0] n_wregno [2];
  bit n_br [2];
  bit n_brwait [2];
  int n_lu [2];
  int n_brc [2];

  always #5 clk = ~clk;

  de_stage_fwd_param #(.DBITS(DB), .REGS(16), .RBITS(RB), .NFWD(NF), .ZERO_HARD(0), .CNTBITS(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs(in_rs), .in_rt(in_rt),
    .in_read_rs(in_read_rs), .in_read_rt(in_read_rt), .in_wr_reg(in_wr_reg),
    .in_wregno(in_wregno), .in_is_br(in_is_br), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
    .fwd_regno(fwd_regno), .fwd_data(fwd_data), .wb_we(wb_we), .wb_regno(wb_regno),
    .wb_data(wb_data), .br_resolve(br_resolve), .flush(flush), .stall_fe(o_stall[0]),
    .out_valid(o_valid[0]), .out_rs_val(o_rs[0]), .out_rt_val(o_rt[0]), .out_wr_reg(o_wr[0]),
    .out_wregno(o_wregno[0]), .out_is_br(o_br[0]), .cnt_lu_stall(c0_lu), .cnt_br_stall(c0_br));

  de_stage_fwd_param #(.DBITS(DB), .REGS(16), .RBITS(RB), .NFWD(NF), .ZERO_HARD(1), .CNTBITS(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs(in_rs), .in_rt(in_rt),
    .in_read_rs(in_read_rs), .in_read_rt(in_read_rt), .in_wr_reg(in_wr_reg),
    .in_wregno(in_wregno), .in_is_br(in_is_br), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
    .fwd_regno(fwd_regno), .fwd_data(fwd_data), .wb_we(wb_we), .wb_regno(wb_regno),
    .wb_data(wb_data), .br_resolve(br_resolve), .flush(flush), .stall_fe(o_stall[1]),
    .out_valid(o_valid[1]), .out_rs_val(o_rs[1]), .out_rt_val(o_rt[1]), .out_wr_reg(o_wr[1]),
    .out_wregno(o_wregno[1]), .out_is_br(o_br[1]), .cnt_lu_stall(c1_lu), .cnt_br_stall(c1_br));

  task automatic checkOutput(input string tag, input int z, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s (zh=%0d) observed=%h expected=%h", tag, z, obs, exp);
  endtask

  function automatic logic [15:0] cnt_lu(input int z);
    return (z == 0) ? c0_lu : {12'd0, c1_lu};
  endfunction

  function automatic logic [15:0] cnt_br(input int z);
    return (z == 0) ? c0_br : {12'd0, c1_br};
  endfunction

  // Youngest matching channel supplies the operand; otherwise WB, otherwise regfile.
  function automatic void model_operand(input int z, input logic [RB-1:0] src,
                                        output logic [DB-1:0] v, output bit haz);
    int hits[$];
    haz = 0;
    v = '0;
    if (z == 1 && src == 4'd0) return;
    for (int i = 0; i < NF; i++)
      if (fwd_valid[i] && fwd_regno[i*RB +: RB] == src) hits.push_back(i);
    if (hits.size() > 0) begin
      v = fwd_data[hits[0]*DB +: DB];
      haz = !fwd_ready[hits[0]];
    end else if (wb_we && wb_regno == src) begin
      v = wb_data;
    end else begin
      v = m_regs[z][src];
    end
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int r = 0; r < 16; r++) m_regs[z][r] = '0;
      m_brwait[z] = 0; m_lu[z] = 0; m_brc[z] = 0;
      e_valid[z] = 0; e_rs[z] = '0; e_rt[z] = '0; e_rdrs[z] = 0; e_rdrt[z] = 0;
      e_wr[z] = 0; e_wregno[z] = '0; e_br[z] = 0;
    end
  endtask

  task automatic model_eval(input int z);
    logic [DB-1:0] vs, vt;
    bit hs, ht, lu;
    model_operand(z, in_rs, vs, hs);
    model_operand(z, in_rt, vt, ht);
    lu = in_valid && ((in_read_rs && hs) || (in_read_rt && ht));
    n_valid[z] = 0; n_rs[z] = '0; n_rt[z] = '0; n_rdrs[z] = 0; n_rdrt[z] = 0;
    n_wr[z] = 0; n_wregno[z] = '0; n_br[z] = 0;
    n_lu[z] = m_lu[z]; n_brc[z] = m_brc[z]; n_brwait[z] = m_brwait[z];
    e_stall[z] = 0;
    if (flush) begin
      n_brwait[z] = 0;
    end else if (m_brwait[z]) begin
      e_stall[z] = 1;
      if (m_brc[z] < cmax[z]) n_brc[z] = m_brc[z] + 1;
      if (br_resolve) n_brwait[z] = 0;
    end else if (lu) begin
      e_stall[z] = 1;
      if (m_lu[z] < cmax[z]) n_lu[z] = m_lu[z] + 1;
    end else begin
      n_valid[z] = in_valid; n_rs[z] = vs; n_rt[z] = vt;
      n_rdrs[z] = in_read_rs; n_rdrt[z] = in_read_rt;
      n_wr[z] = in_wr_reg; n_wregno[z] = in_wregno; n_br[z] = in_is_br;
      n_brwait[z] = in_valid && in_is_br;
    end
  endtask

  task automatic model_commit(input int z, input bit we, input logic [RB-1:0] wn, input logic [DB-1:0] wd);
    if (we && !(z == 1 && wn == 4'd0)) m_regs[z][wn] = wd;
    e_valid[z] = n_valid[z]; e_rs[z] = n_rs[z]; e_rt[z] = n_rt[z];
    e_rdrs[z] = n_rdrs[z]; e_rdrt[z] = n_rdrt[z]; e_wr[z] = n_wr[z];
    e_wregno[z] = n_wregno[z]; e_br[z] = n_br[z];
    m_brwait[z] = n_brwait[z]; m_lu[z] = n_lu[z]; m_brc[z] = n_brc[z];
  endtask

  // One clock: check combinational stall before the edge, latch outputs after it.
  task automatic applyStimulus();
    bit we;
    logic [RB-1:0] wn;
    logic [DB-1:0] wd;
    #2;
    we = wb_we; wn = wb_regno; wd = wb_data;
    for (int z = 0; z < 2; z++) begin
      model_eval(z);
      checkOutput("stall_fe", z, {31'd0, o_stall[z]}, {31'd0, e_stall[z]});
    end
    @(posedge clk);
    #1;
    for (int z = 0; z < 2; z++) begin
      model_commit(z, we, wn, wd);
      checkOutput("out_valid", z, {31'd0, o_valid[z]}, {31'd0, e_valid[z]});
      checkOutput("out_wr_reg", z, {31'd0, o_wr[z]}, {31'd0, e_wr[z]});
      checkOutput("out_wregno", z, {28'd0, o_wregno[z]}, {28'd0, e_wregno[z]});
      checkOutput("out_is_br", z, {31'd0, o_br[z]}, {31'd0, e_br[z]});
      checkOutput("cnt_lu_stall", z, {16'd0, cnt_lu(z)}, m_lu[z]);
      checkOutput("cnt_br_stall", z, {16'd0, cnt_br(z)}, m_brc[z]);
      if (!e_valid[z] || e_rdrs[z]) checkOutput("out_rs_val", z, o_rs[z], e_rs[z]);
      if (!e_valid[z] || e_rdrt[z]) checkOutput("out_rt_val", z, o_rt[z], e_rt[z]);
    end
  endtask

  task automatic checkReset();
    for (int z = 0; z < 2; z++) begin
      checkOutput("rst_valid", z, {31'd0, o_valid[z]}, '0);
      checkOutput("rst_rs", z, o_rs[z], '0);
      checkOutput("rst_rt", z, o_rt[z], '0);
      checkOutput("rst_wr", z, {31'd0, o_wr[z]}, '0);
      checkOutput("rst_wregno", z, {28'd0, o_wregno[z]}, '0);
      checkOutput("rst_br", z, {31'd0, o_br[z]}, '0);
      checkOutput("rst_cnt_lu", z, {16'd0, cnt_lu(z)}, '0);
      checkOutput("rst_cnt_br", z, {16'd0, cnt_br(z)}, '0);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_rs = '0; in_rt = '0; in_read_rs = 0; in_read_rt = 0;
    in_wr_reg = 0; in_wregno = '0; in_is_br = 0;
    fwd_valid = '0; fwd_ready = '0; fwd_regno = '0; fwd_data = '0;
    wb_we = 0; wb_regno = '0; wb_data = '0; br_resolve = 0; flush = 0;
  endtask

  task automatic set_ch(input int i, input bit v, input bit r, input logic [RB-1:0] n, input logic [DB-1:0] d);
    fwd_valid[i] = v;
    fwd_ready[i] = r;
    fwd_regno[i*RB +: RB] = n;
    fwd_data[i*DB +: DB] = d;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    #3;
    checkReset();
    model_reset();
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;

    // preload r3 through writeback
    wb_we = 1; wb_regno = 4'd3; wb_data = 32'h33;
    applyStimulus();

    // forward priority: channel 0 beats channel 1 and the regfile
    wb_we = 0;
    set_ch(0, 1, 1, 4'd3, 32'h11);
    set_ch(1, 1, 1, 4'd3, 32'h22);
    in_valid = 1; in_rs = 4'd3; in_read_rs = 1; in_wr_reg = 1; in_wregno = 4'd4;
    applyStimulus();
    checkOutput("fwd_priority", 0, o_rs[0], 32'h11);

    // load-use on rt, then the load has moved to channel 1 with data ready
    clear_inputs();
    set_ch(0, 1, 0, 4'd5, 32'hDEAD);
    in_valid = 1; in_rt = 4'd5; in_read_rt = 1;
    applyStimulus();
    checkOutput("lu_valid", 0, {31'd0, o_valid[0]}, '0);
    checkOutput("lu_count", 0, {16'd0, c0_lu}, 32'd1);
    set_ch(0, 0, 0, 4'd0, 32'h0);
    set_ch(1, 1, 1, 4'd5, 32'h7);
    applyStimulus();
    checkOutput("lu_release", 0, o_rt[0], 32'h7);

    // writeback bypass and later regfile read
    clear_inputs();
    wb_we = 1; wb_regno = 4'd9; wb_data = 32'hABCD;
    in_valid = 1; in_rs = 4'd9; in_read_rs = 1;
    applyStimulus();
    checkOutput("wb_bypass", 0, o_rs[0], 32'hABCD);
    wb_we = 0;
    applyStimulus();
    checkOutput("rf_read", 0, o_rs[0], 32'hABCD);

    // branch wait: issue, 3 unresolved cycles, resolve pulse
    clear_inputs();
    in_valid = 1; in_is_br = 1;
    applyStimulus();
    in_is_br = 0; in_wr_reg = 1; in_wregno = 4'd2;
    for (int k = 0; k < 3; k++) applyStimulus();
    br_resolve = 1;
    applyStimulus();
    checkOutput("br_count", 0, {16'd0, c0_br}, 32'd4);
    br_resolve = 0;
    applyStimulus();
    checkOutput("br_after", 0, {31'd0, o_valid[0]}, 32'd1);

    // flush during branch wait
    clear_inputs();
    in_valid = 1; in_is_br = 1;
    applyStimulus();
    in_is_br = 0; flush = 1;
    applyStimulus();
    flush = 0;
    applyStimulus();

    // register 0 with a pending load on channel 0
    clear_inputs();
    set_ch(0, 1, 0, 4'd0, 32'h55);
    in_valid = 1; in_rs = 4'd0; in_read_rs = 1;
    applyStimulus();
    checkOutput("zero_hard_rs", 1, o_rs[1], '0);

    // async reset in the middle of a load-use stall
    clear_inputs();
    set_ch(0, 1, 0, 4'd5, 32'h1);
    in_valid = 1; in_rt = 4'd5; in_read_rt = 1;
    applyStimulus();
    #2;
    reset = 1;
    #1;
    checkReset();
    model_reset();
    #1;
    reset = 0;
    clear_inputs();
    in_valid = 1; in_rs = 4'd9; in_read_rs = 1;
    applyStimulus();
    checkOutput("rf_after_reset", 0, o_rs[0], '0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_rs = 4'($urandom_range(0, 7));
      in_rt = 4'($urandom_range(0, 7));
      in_read_rs = 1'($urandom_range(0, 1));
      in_read_rt = 1'($urandom_range(0, 1));
      in_wr_reg = 1'($urandom_range(0, 1));
      in_wregno = 4'($urandom_range(0, 15));
      in_is_br = $urandom_range(0, 7) == 0;
      for (int i = 0; i < NF; i++)
        set_ch(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), $urandom);
      wb_we = 1'($urandom_range(0, 1));
      wb_regno = 4'($urandom_range(0, 7));
      wb_data = $urandom;
      br_resolve = $urandom_range(0, 2) == 0;
      flush = $urandom_range(0, 15) == 0;
      applyStimulus();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
